uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter between NUM_CPUS cores and sequences it on their behalf.
- Each core presents one 32-bit write word with byte strobes. The arbiter grants cores round-robin, serializes the strobed bytes lowest lane first, and drives the UART i_Tx_DV/i_Tx_Byte handshake.
- Optional line lock keeps one core's output unbroken until it sends a newline, so console lines from different cores never interleave.
- Sits between the per-core UART write FIFOs of the interconnect and the UART TX block.

---
 rtl/uart_tx_arbiter.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that serialises the strobed bytes of per-core words onto one UART
// transmitter, with an optional line lock so console lines from different cores never interleave.
module uart_tx_arbiter #(
  parameter int unsigned NUM_CPUS     = 2,
  parameter int unsigned LOCK_EN      = 1,
  parameter int unsigned LOCK_TIMEOUT = 1024,
  localparam int unsigned GW          = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CPUS-1:0]    req_valid,
  input  logic [NUM_CPUS*32-1:0] req_wdata,
  input  logic [NUM_CPUS*4-1:0]  req_wstrb,
  output logic [NUM_CPUS-1:0]    req_ready,
  output logic                   i_Tx_DV,
  output logic [7:0]             i_Tx_Byte,
  input  logic                   o_Tx_Active,
  input  logic                   o_Tx_Done,
  output logic [GW-1:0]          grant_id,
  output logic                   busy,
  output logic                   locked
);

  localparam int unsigned TW = $clog2(LOCK_TIMEOUT) + 1;

  typedef enum logic [1:0] {StIdle, StSend, StWait, StNext} state_e;

  state_e        state_q;
  logic [GW-1:0] rr_ptr_q;
  logic [GW-1:0] owner_q;
  logic [TW-1:0] tmo_q;
  logic [31:0]   word_q;
  logic [3:0]    strb_q;
  logic [1:0]    lane_q;
  logic          nl_q;

  logic                pick_found;
  logic [GW-1:0]       pick_idx;
  logic [GW-1:0]       cand;
  logic [NUM_CPUS-1:0] pick_oh;
  logic [31:0]         pick_word;
  logic [3:0]          pick_strb;
  logic [1:0]          first_lane;
  logic                nxt_found;
  logic [1:0]          nxt_lane;
  logic [7:0]          cur_byte;

  // Descending scan so the candidate closest to rr_ptr_q wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    if (locked) begin
      pick_found = req_valid[owner_q];
      pick_idx   = owner_q;
    end else begin
      for (int k = int'(NUM_CPUS) - 1; k >= 0; k--) begin
        cand = GW'((int'(rr_ptr_q) + k) % int'(NUM_CPUS));
        if (req_valid[cand]) begin
          pick_found = 1'b1;
          pick_idx   = cand;
        end
      end
    end
    pick_oh = '0;
    if (pick_found) pick_oh[pick_idx] = 1'b1;
  end

  always_comb begin
    pick_word  = req_wdata[{pick_idx, 5'd0} +: 32];
    pick_strb  = req_wstrb[{pick_idx, 2'd0} +: 4];
    first_lane = '0;
    for (int l = 3; l >= 0; l--) begin
      if (pick_strb[l]) first_lane = 2'(l);
    end
    nxt_found = 1'b0;
    nxt_lane  = '0;
    for (int l = 3; l >= 0; l--) begin
      if (strb_q[l] && (l > int'(lane_q))) begin
        nxt_found = 1'b1;
        nxt_lane  = 2'(l);
      end
    end
    cur_byte = word_q[{lane_q, 3'd0} +: 8];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      tmo_q     <= '0;
      word_q    <= '0;
      strb_q    <= '0;
      lane_q    <= '0;
      nl_q      <= 1'b0;
      req_ready <= '0;
      i_Tx_DV   <= 1'b0;
      i_Tx_Byte <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
      locked    <= 1'b0;
    end else begin
      req_ready <= '0;
      i_Tx_DV   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pick_found) begin
            req_ready <= pick_oh;
            word_q    <= pick_word;
            strb_q    <= pick_strb;
            lane_q    <= first_lane;
            grant_id  <= pick_idx;
            tmo_q     <= '0;
            nl_q      <= 1'b0;
            busy      <= 1'b1;
            state_q   <= (pick_strb == 4'b0000) ? StNext : StSend;
          end else if (locked) begin
            // Release when this increment would bring the counter to LOCK_TIMEOUT-1.
            if (tmo_q == TW'(LOCK_TIMEOUT - 2)) begin
              locked <= 1'b0;
              tmo_q  <= '0;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
        end
        StSend: begin
          if (!o_Tx_Active) begin
            i_Tx_DV   <= 1'b1;
            i_Tx_Byte <= cur_byte;
            state_q   <= StWait;
          end
        end
        StWait: begin
          // A Done coincident with our own DV belongs to an earlier byte.
          if (o_Tx_Done && !i_Tx_DV) begin
            if (i_Tx_Byte == 8'h0A) begin
              locked <= 1'b0;
              nl_q   <= 1'b1;
            end
            if (nxt_found) begin
              lane_q  <= nxt_lane;
              state_q <= StSend;
            end else begin
              state_q <= StNext;
            end
          end
        end
        StNext: begin
          if ((LOCK_EN != 0) && (strb_q != 4'b0000) && !nl_q) begin
            locked  <= 1'b1;
            owner_q <= grant_id;
          end
          rr_ptr_q <= (grant_id == GW'(NUM_CPUS - 1)) ? '0 : grant_id + 1'b1;
          busy     <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: instance 0 runs without line lock, instance 1 with lock and a
// short timeout; expected grant order and byte streams come from a word-level model.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     [2];
  logic [1:0]  req_valid [2];
  logic [63:0] req_wdata [2];
  logic [7:0]  req_wstrb [2];
  logic [1:0]  req_ready [2];
  logic        tx_dv     [2];
  logic [7:0]  tx_byte   [2];
  logic        tx_act    [2];
  logic        tx_done   [2] = '{1'b0, 1'b0};
  logic [0:0]  gid       [2];
  logic        busy      [2];
  logic        locked    [2];

  uart_tx_arbiter #(.NUM_CPUS(2), .LOCK_EN(0), .LOCK_TIMEOUT(1024)) dut0 (
    .clk(clk), .rst(rst_n[0]), .req_valid(req_valid[0]), .req_wdata(req_wdata[0]),
    .req_wstrb(req_wstrb[0]), .req_ready(req_ready[0]), .i_Tx_DV(tx_dv[0]),
    .i_Tx_Byte(tx_byte[0]), .o_Tx_Active(tx_act[0]), .o_Tx_Done(tx_done[0]),
    .grant_id(gid[0]), .busy(busy[0]), .locked(locked[0])
  );

  uart_tx_arbiter #(.NUM_CPUS(2), .LOCK_EN(1), .LOCK_TIMEOUT(8)) dut1 (
    .clk(clk), .rst(rst_n[1]), .req_valid(req_valid[1]), .req_wdata(req_wdata[1]),
    .req_wstrb(req_wstrb[1]), .req_ready(req_ready[1]), .i_Tx_DV(tx_dv[1]),
    .i_Tx_Byte(tx_byte[1]), .o_Tx_Active(tx_act[1]), .o_Tx_Done(tx_done[1]),
    .grant_id(gid[1]), .busy(busy[1]), .locked(locked[1])
  );

  // UART model: busy for lat+tail cycles after DV, Done pulse once lat has elapsed.
  int ucnt [2] = '{0, 0};
  int lat  [2];
  int tail [2];
  int dv_busy_err = 0;
  assign tx_act[0] = (ucnt[0] != 0);
  assign tx_act[1] = (ucnt[1] != 0);
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      tx_done[g] <= (ucnt[g] == tail[g] + 1);
      if (tx_dv[g]) begin
        if (ucnt[g] != 0) dv_busy_err <= dv_busy_err + 1;
        ucnt[g] <= lat[g] + tail[g];
      end else if (ucnt[g] != 0) begin
        ucnt[g] <= ucnt[g] - 1;
      end
    end
  end

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int done_cnt, err_oh;
  logic [35:0] fq0 [$];
  logic [35:0] fq1 [$];
  logic [8:0]  obs_b [$];
  logic [8:0]  exp_b [$];
  int obs_acc [$];
  int exp_acc [$];
  int dv_cyc  [$];
  int acc_cyc [$];

  task automatic drive(input int s);
    req_valid[s] = {fq1.size() > 0, fq0.size() > 0};
    req_wdata[s] = {(fq1.size() > 0) ? fq1[0][31:0] : 32'h0,
                    (fq0.size() > 0) ? fq0[0][31:0] : 32'h0};
    req_wstrb[s] = {(fq1.size() > 0) ? fq1[0][35:32] : 4'h0,
                    (fq0.size() > 0) ? fq0[0][35:32] : 4'h0};
  endtask

  // One cycle: sample outputs mid-cycle, pop accepted words, present the FIFO heads.
  task automatic step(input int s);
    @(negedge clk);
    cyc++;
    if (tx_dv[s]) begin
      obs_b.push_back({gid[s], tx_byte[s]});
      dv_cyc.push_back(cyc);
    end
    if (tx_done[s]) done_cnt++;
    if (!$onehot0(req_ready[s])) err_oh++;
    if (req_ready[s][0]) begin
      obs_acc.push_back(0);
      acc_cyc.push_back(cyc);
      if (fq0.size() > 0) fq0.delete(0);
    end
    if (req_ready[s][1]) begin
      obs_acc.push_back(1);
      acc_cyc.push_back(cyc);
      if (fq1.size() > 0) fq1.delete(0);
    end
    drive(s);
  endtask

  task automatic clear_obs();
    obs_b.delete(); exp_b.delete(); obs_acc.delete(); exp_acc.delete();
    dv_cyc.delete(); acc_cyc.delete();
    done_cnt = 0;
    err_oh   = 0;
  endtask

  task automatic reset_dut(input int s);
    fq0.delete(); fq1.delete();
    rst_n[s] = 1'b0;
    drive(s);
    repeat (3) step(s);
    rst_n[s] = 1'b1;
    clear_obs();
  endtask

  // Reference model: a granted word yields one accept and its strobed bytes, low lane first.
  task automatic expect_word(input int core, input logic [35:0] w);
    logic c;
    c = core[0];
    exp_acc.push_back(core);
    for (int l = 0; l < 4; l++) begin
      if (w[32+l]) exp_b.push_back({c, w[8*l +: 8]});
    end
  endtask

  task automatic drain(input int s, input string what);
    int c;
    c = 0;
    while (c < 2000 && !(fq0.size() == 0 && fq1.size() == 0 && !busy[s])) begin
      step(s);
      c++;
    end
    total++;
    if (c >= 2000) $display("FAIL %s drain: still busy after %0d cycles", what, c);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n[0] = 1'b0; rst_n[1] = 1'b0;
    drive(0); drive(1);
    repeat (3) step(0);
    for (int s = 0; s < 2; s++) begin
      total++;
      if ({req_ready[s], tx_dv[s], tx_byte[s], gid[s], busy[s], locked[s]} !== 14'd0)
        $display("FAIL reset inst%0d: got %h want 0", s,
                 {req_ready[s], tx_dv[s], tx_byte[s], gid[s], busy[s], locked[s]});
      else passed++;
    end
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
  endtask

  task automatic test_single_word();
    lat[0] = 9; tail[0] = 0;
    reset_dut(0);
    fq0.push_back({4'hF, 32'h44434241});
    expect_word(0, {4'hF, 32'h44434241});
    drain(0, "single");
    total++;
    if (obs_b.size() != 4) $display("FAIL single count: got %0d want 4", obs_b.size());
    else passed++;
    foreach (exp_b[k]) begin
      total++;
      if (obs_b[k] !== exp_b[k]) $display("FAIL single byte%0d: got %h want %h", k, obs_b[k], exp_b[k]);
      else passed++;
    end
    total++;
    if (obs_acc.size() != 1) $display("FAIL single ready pulses: got %0d want 1", obs_acc.size());
    else passed++;
    total++;
    if (dv_cyc[0] - acc_cyc[0] != 1)
      $display("FAIL single latency: got %0d want 1", dv_cyc[0] - acc_cyc[0]);
    else passed++;
    total++;
    if (done_cnt != 4) $display("FAIL single done count: got %0d want 4", done_cnt);
    else passed++;
  endtask

  task automatic test_round_robin();
    logic [35:0] w;
    lat[0] = 3; tail[0] = 0;
    reset_dut(0);
    for (int k = 0; k < 4; k++) begin
      w = {4'b0001, 24'h0, 8'(8'h10 + k)}; fq0.push_back(w);
      w = {4'b0001, 24'h0, 8'(8'h20 + k)}; fq1.push_back(w);
    end
    for (int k = 0; k < 4; k++) begin
      expect_word(0, {4'b0001, 24'h0, 8'(8'h10 + k)});
      expect_word(1, {4'b0001, 24'h0, 8'(8'h20 + k)});
    end
    drain(0, "rr");
    foreach (exp_acc[k]) begin
      total++;
      if (obs_acc[k] !== exp_acc[k]) $display("FAIL rr grant%0d: got %0d want %0d", k, obs_acc[k], exp_acc[k]);
      else passed++;
    end
    foreach (exp_b[k]) begin
      total++;
      if (obs_b[k] !== exp_b[k]) $display("FAIL rr byte%0d: got %h want %h", k, obs_b[k], exp_b[k]);
      else passed++;
    end
  endtask

  task automatic test_lock();
    int idle_seen;
    bit nl_pushed, lock_bad, done3, got_after, fin;
    logic lock_after;
    lat[1] = 4; tail[1] = 0;
    reset_dut(1);
    idle_seen = 0; nl_pushed = 0; lock_bad = 0; done3 = 0; got_after = 0; fin = 0;
    lock_after = 1'bx;
    fq0.push_back({4'b0011, 32'h00004241});
    fq1.push_back({4'b0001, 32'h0000005A});
    expect_word(0, {4'b0011, 32'h00004241});
    expect_word(0, {4'b0001, 32'h0000000A});
    expect_word(1, {4'b0001, 32'h0000005A});
    for (int c = 0; c < 600 && !fin; c++) begin
      step(1);
      if (obs_acc.size() == 1 && !busy[1]) begin
        idle_seen++;
        if (!locked[1]) lock_bad = 1;
      end
      if (!nl_pushed && idle_seen == 3) begin
        fq0.push_back({4'b0001, 32'h0000000A});
        nl_pushed = 1;
      end
      if (done3 && !got_after) begin
        lock_after = locked[1];
        got_after  = 1;
      end
      if (done_cnt == 3) done3 = 1;
      if (nl_pushed && fq0.size() == 0 && fq1.size() == 0 && !busy[1]) fin = 1;
    end
    total++;
    if (!fin) $display("FAIL lock run: did not complete, accepts %0d", obs_acc.size());
    else passed++;
    total++;
    if (lock_bad) $display("FAIL lock held in gap: got 0 want 1");
    else passed++;
    foreach (exp_acc[k]) begin
      total++;
      if (obs_acc[k] !== exp_acc[k]) $display("FAIL lock grant%0d: got %0d want %0d", k, obs_acc[k], exp_acc[k]);
      else passed++;
    end
    foreach (exp_b[k]) begin
      total++;
      if (obs_b[k] !== exp_b[k]) $display("FAIL lock byte%0d: got %h want %h", k, obs_b[k], exp_b[k]);
      else passed++;
    end
    total++;
    if (lock_after !== 1'b0) $display("FAIL lock after newline: got %b want 0", lock_after);
    else passed++;
    total++;
    if ({locked[1], gid[1]} !== 2'b11) $display("FAIL lock new owner: got %b want 11", {locked[1], gid[1]});
    else passed++;
  endtask

  task automatic test_timeout();
    int lk, ul;
    bit ok;
    lat[1] = 3; tail[1] = 0;
    reset_dut(1);
    lk = 0; ul = 0; ok = 0;
    fq0.push_back({4'b0001, 32'h00000041});
    fq1.push_back({4'b0001, 32'h0000005A});
    for (int c = 0; c < 300 && !ok; c++) begin
      step(1);
      if (obs_acc.size() == 1 && !busy[1]) begin
        if (locked[1]) lk++;
        else ul++;
      end
      if (obs_acc.size() >= 2) ok = 1;
    end
    total++;
    if (!ok) $display("FAIL timeout grant: core1 never granted");
    else passed++;
    total++;
    if (lk != 7) $display("FAIL timeout locked idle cycles: got %0d want 7", lk);
    else passed++;
    total++;
    if (ul != 1) $display("FAIL timeout unlocked idle cycles: got %0d want 1", ul);
    else passed++;
    total++;
    if (obs_acc[1] !== 1) $display("FAIL timeout second grant: got %0d want 1", obs_acc[1]);
    else passed++;
    drain(1, "timeout");
  endtask

  task automatic test_strobes();
    lat[0] = 5; tail[0] = 2;
    reset_dut(0);
    fq0.push_back({4'b0000, 32'h44434241});
    expect_word(0, {4'b0000, 32'h44434241});
    drain(0, "zero strobe");
    total++;
    if (obs_acc.size() != 1 || obs_b.size() != 0)
      $display("FAIL zero strobe: got %0d accepts %0d bytes want 1 accepts 0 bytes",
               obs_acc.size(), obs_b.size());
    else passed++;
    fq0.push_back({4'b1010, 32'h44434241});
    fq1.push_back({4'b1010, 32'h88878685});
    expect_word(1, {4'b1010, 32'h88878685});
    expect_word(0, {4'b1010, 32'h44434241});
    drain(0, "sparse strobe");
    foreach (exp_acc[k]) begin
      total++;
      if (obs_acc[k] !== exp_acc[k]) $display("FAIL strb grant%0d: got %0d want %0d", k, obs_acc[k], exp_acc[k]);
      else passed++;
    end
    foreach (exp_b[k]) begin
      total++;
      if (obs_b[k] !== exp_b[k]) $display("FAIL strb byte%0d: got %h want %h", k, obs_b[k], exp_b[k]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int c;
    lat[0] = 9; tail[0] = 0;
    reset_dut(0);
    fq0.push_back({4'b0001, 32'h00000031});
    drain(0, "pre reset");
    fq1.push_back({4'b1111, 32'h64636261});
    c = 0;
    while (c < 200 && obs_b.size() < 2) begin step(0); c++; end
    total++;
    if (obs_b.size() < 2) $display("FAIL mid reset setup: got %0d bytes want 2", obs_b.size());
    else passed++;
    repeat (2) step(0);
    rst_n[0] = 1'b0;
    fq1.delete();
    drive(0);
    step(0);
    total++;
    if ({tx_dv[0], busy[0], locked[0], gid[0]} !== 4'b0)
      $display("FAIL mid reset outputs: got %b want 0000", {tx_dv[0], busy[0], locked[0], gid[0]});
    else passed++;
    rst_n[0] = 1'b1;
    clear_obs();
    fq0.push_back({4'b0001, 32'h00000071});
    fq1.push_back({4'b0001, 32'h00000072});
    expect_word(0, {4'b0001, 32'h00000071});
    expect_word(1, {4'b0001, 32'h00000072});
    drain(0, "post reset");
    repeat (15) step(0);
    total++;
    if (obs_b.size() != exp_b.size()) $display("FAIL mid reset byte count: got %0d want %0d", obs_b.size(), exp_b.size());
    else passed++;
    foreach (exp_acc[k]) begin
      total++;
      if (obs_acc[k] !== exp_acc[k] || obs_b[k] !== exp_b[k])
        $display("FAIL mid reset word%0d: got %0d/%h want %0d/%h", k, obs_acc[k], obs_b[k], exp_acc[k], exp_b[k]);
      else passed++;
    end
  endtask

  task automatic test_random();
    logic [35:0] w0 [$];
    logic [35:0] w1 [$];
    logic [35:0] w;
    int n0, n1, ptr, c, i0, i1;
    for (int it = 0; it < 3; it++) begin
      lat[0] = int'($urandom_range(1, 6)); tail[0] = int'($urandom_range(0, 3));
      reset_dut(0);
      w0.delete(); w1.delete();
      n0 = int'($urandom_range(1, 6)); n1 = int'($urandom_range(1, 6));
      for (int k = 0; k < n0; k++) begin
        w = {4'($urandom_range(0, 15)), 32'($urandom)}; w0.push_back(w); fq0.push_back(w);
      end
      for (int k = 0; k < n1; k++) begin
        w = {4'($urandom_range(0, 15)), 32'($urandom)}; w1.push_back(w); fq1.push_back(w);
      end
      // Both FIFOs full from reset: strict alternation from core0 until one side runs dry.
      ptr = 0; i0 = 0; i1 = 0;
      while (i0 < n0 || i1 < n1) begin
        c = ((ptr == 0 && i0 < n0) || (ptr == 1 && i1 >= n1)) ? 0 : 1;
        if (c == 0) begin expect_word(0, w0[i0]); i0++; end
        else begin expect_word(1, w1[i1]); i1++; end
        ptr = 1 - c;
      end
      drain(0, "random");
      total++;
      if (obs_b.size() != exp_b.size() || obs_acc.size() != exp_acc.size())
        $display("FAIL random it%0d sizes: got %0d/%0d want %0d/%0d", it,
                 obs_b.size(), obs_acc.size(), exp_b.size(), exp_acc.size());
      else passed++;
      foreach (exp_acc[k]) begin
        total++;
        if (obs_acc[k] !== exp_acc[k]) $display("FAIL random it%0d grant%0d: got %0d want %0d", it, k, obs_acc[k], exp_acc[k]);
        else passed++;
      end
      foreach (exp_b[k]) begin
        total++;
        if (obs_b[k] !== exp_b[k]) $display("FAIL random it%0d byte%0d: got %h want %h", it, k, obs_b[k], exp_b[k]);
        else passed++;
      end
      total++;
      if (err_oh != 0 || dv_busy_err != 0)
        $display("FAIL random it%0d protocol: got %0d multi-ready %0d dv-while-active want 0",
                 it, err_oh, dv_busy_err);
      else passed++;
    end
  endtask

  initial begin
    lat[0] = 9; lat[1] = 9; tail[0] = 0; tail[1] = 0;
    fq0.delete(); fq1.delete();
    clear_obs();
    test_reset();
    test_single_word();
    test_round_robin();
    test_lock();
    test_timeout();
    test_strobes();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
